// File: rtl/tape_ram_arbiter.sv
// rtl/tape_ram_arbiter.sv - shares the byte-wide SDRAM port between the TAP loader (writes) and tape player (reads)
module tape_ram_arbiter #(
  parameter int FIFO_DEPTH = 4,
  parameter int AW         = 25
) (
  input  logic          clk,
  input  logic          reset_n,
  input  logic          ld_active,
  input  logic          ld_wr,
  input  logic [AW-1:0] ld_addr,
  input  logic [7:0]    ld_din,
  output logic          ld_overflow,
  input  logic          tp_rd,
  input  logic [AW-1:0] tp_addr,
  output logic [7:0]    tp_dout,
  output logic          tp_valid,
  output logic [AW-1:0] mem_addr,
  output logic [7:0]    mem_din,
  output logic          mem_we,
  output logic          mem_rd,
  input  logic [7:0]    mem_dout,
  input  logic          mem_ack,
  output logic          busy
);

  localparam int PW = $clog2(FIFO_DEPTH);
  localparam logic [PW:0] PTR_ONE = 1;

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_WR   = 2'd1;
  localparam logic [1:0] S_RD   = 2'd2;

  logic [1:0]    state;
  logic [AW-1:0] fifo_addr [FIFO_DEPTH];
  logic [7:0]    fifo_data [FIFO_DEPTH];
  logic [PW:0]   wr_ptr;
  logic [PW:0]   rd_ptr;
  logic          rd_pend;
  logic [AW-1:0] rd_addr;
  logic          ld_active_d;

  logic empty;
  logic full;
  logic pop;
  logic push;
  logic go_wr;
  logic go_rd;
  logic ld_active_rise;

  assign empty = (wr_ptr == rd_ptr);
  assign full  = (wr_ptr[PW] != rd_ptr[PW]) && (wr_ptr[PW-1:0] == rd_ptr[PW-1:0]);
  assign pop   = (state == S_WR) && mem_ack;
  // A pop in the same cycle frees the head slot, so a push into a full FIFO is still accepted.
  assign push  = ld_wr && (!full || pop);
  assign go_wr = (state == S_IDLE) && !empty;
  assign go_rd = (state == S_IDLE) && empty && rd_pend && !ld_active;
  assign ld_active_rise = ld_active && !ld_active_d;
  assign busy  = (state != S_IDLE) || !empty || rd_pend;

  always_ff @(posedge clk) begin
    if (push) begin
      fifo_addr[wr_ptr[PW-1:0]] <= ld_addr;
      fifo_data[wr_ptr[PW-1:0]] <= ld_din;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state       <= S_IDLE;
      wr_ptr      <= '0;
      rd_ptr      <= '0;
      rd_pend     <= 1'b0;
      rd_addr     <= '0;
      ld_active_d <= 1'b0;
      ld_overflow <= 1'b0;
      mem_addr    <= '0;
      mem_din     <= '0;
      mem_we      <= 1'b0;
      mem_rd      <= 1'b0;
      tp_dout     <= '0;
      tp_valid    <= 1'b0;
    end else begin
      ld_active_d <= ld_active;
      tp_valid    <= (state == S_RD) && mem_ack;

      if (push) wr_ptr <= wr_ptr + PTR_ONE;
      if (pop)  rd_ptr <= rd_ptr + PTR_ONE;

      if (ld_wr && !push) ld_overflow <= 1'b1;
      else if (ld_active_rise) ld_overflow <= 1'b0;

      // A request arriving while a read is in flight queues a fresh read; the in-flight address is untouched.
      if (tp_rd) begin
        rd_pend <= 1'b1;
        rd_addr <= tp_addr;
      end else if (go_rd) begin
        rd_pend <= 1'b0;
      end

      case (state)
        S_IDLE: begin
          if (go_wr) begin
            state    <= S_WR;
            mem_we   <= 1'b1;
            mem_addr <= fifo_addr[rd_ptr[PW-1:0]];
            mem_din  <= fifo_data[rd_ptr[PW-1:0]];
          end else if (go_rd) begin
            state    <= S_RD;
            mem_rd   <= 1'b1;
            mem_addr <= rd_addr;
          end
        end
        S_WR: begin
          if (mem_ack) begin
            state  <= S_IDLE;
            mem_we <= 1'b0;
          end
        end
        S_RD: begin
          if (mem_ack) begin
            state   <= S_IDLE;
            mem_rd  <= 1'b0;
            tp_dout <= mem_dout;
          end
        end
        default: begin
          state  <= S_IDLE;
          mem_we <= 1'b0;
          mem_rd <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_tape_ram_arbiter.sv
// tb/tb_tape_ram_arbiter.sv - directed table-driven bench for tape_ram_arbiter
module tb_tape_ram_arbiter;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        ld_active;
  logic        ld_wr;
  logic [24:0] ld_addr;
  logic [7:0]  ld_din;
  logic        ld_overflow;
  logic        tp_rd;
  logic [24:0] tp_addr;
  logic [7:0]  tp_dout;
  logic        tp_valid;
  logic [24:0] mem_addr;
  logic [7:0]  mem_din;
  logic        mem_we;
  logic        mem_rd;
  logic [7:0]  mem_dout;
  logic        mem_ack;
  logic        busy;

  tape_ram_arbiter #(.FIFO_DEPTH(4), .AW(25)) dut (
    .clk(clk), .reset_n(reset_n),
    .ld_active(ld_active), .ld_wr(ld_wr), .ld_addr(ld_addr), .ld_din(ld_din),
    .ld_overflow(ld_overflow),
    .tp_rd(tp_rd), .tp_addr(tp_addr), .tp_dout(tp_dout), .tp_valid(tp_valid),
    .mem_addr(mem_addr), .mem_din(mem_din), .mem_we(mem_we), .mem_rd(mem_rd),
    .mem_dout(mem_dout), .mem_ack(mem_ack), .busy(busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        la;
    logic        wr;
    logic [24:0] wa;
    logic [7:0]  wd;
    logic        rd;
    logic [24:0] ra;
    logic        ack;
    logic [7:0]  dout;
    logic        e_we;
    logic        e_rd;
    logic [24:0] e_addr;
    logic [7:0]  e_din;
    logic        e_tv;
    logic [7:0]  e_tdout;
    logic        e_busy;
    logic        e_ovf;
  } vec_t;

  vec_t tbl[$];
  int   n_vec = 0;
  int   n_err = 0;

  task automatic add(input int la, input int wr, input int wa, input int wd,
                     input int rd, input int ra, input int ack, input int dout,
                     input int we, input int rdc, input int addr, input int din,
                     input int tv, input int tdout, input int bsy, input int ovf);
    vec_t v;
    v.la = 1'(la);     v.wr = 1'(wr);       v.wa = 25'(wa);       v.wd = 8'(wd);
    v.rd = 1'(rd);     v.ra = 25'(ra);      v.ack = 1'(ack);      v.dout = 8'(dout);
    v.e_we = 1'(we);   v.e_rd = 1'(rdc);    v.e_addr = 25'(addr); v.e_din = 8'(din);
    v.e_tv = 1'(tv);   v.e_tdout = 8'(tdout); v.e_busy = 1'(bsy); v.e_ovf = 1'(ovf);
    tbl.push_back(v);
  endtask

  task automatic chk(input string name, input int idx, input logic [31:0] act, input logic [31:0] exp);
    if (act !== exp) begin
      $display("FAIL %s (step %0d): got %h, want %h", name, idx, act, exp);
      n_err++;
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic expect_write(input int idx, input logic [24:0] addr, input logic [7:0] din);
    for (int k = 0; k < 8 && !mem_we; k++) tick();
    n_vec++;
    chk("write_issued", idx, 32'(mem_we), 32'd1);
    chk("write_addr", idx, 32'(mem_addr), 32'(addr));
    chk("write_din", idx, 32'(mem_din), 32'(din));
    chk("write_no_rd", idx, 32'(mem_rd), 32'd0);
    mem_ack = 1'b1;
    tick();
    mem_ack = 1'b0;
    chk("write_drop", idx, 32'(mem_we), 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    reset_n = 1'b0; ld_active = 1'b0; ld_wr = 1'b0; ld_addr = '0; ld_din = '0;
    tp_rd = 1'b0; tp_addr = '0; mem_dout = '0; mem_ack = 1'b0;

    //   la wr wa     wd    rd ra     ak dout | we rd addr   din   tv tdout bsy ovf
    add(0, 0, 0,     0,    0, 0,     0, 0,     0, 0, 0,     0,    0, 0,    0, 0);
    add(0, 1, 'h10,  'hA5, 0, 0,     0, 0,     0, 0, 0,     0,    0, 0,    1, 0);
    add(0, 0, 0,     0,    0, 0,     0, 0,     1, 0, 'h10,  'hA5, 0, 0,    1, 0);
    add(0, 0, 0,     0,    0, 0,     0, 0,     1, 0, 'h10,  'hA5, 0, 0,    1, 0);
    add(0, 0, 0,     0,    0, 0,     1, 0,     0, 0, 0,     0,    0, 0,    0, 0);
    add(1, 0, 0,     0,    1, 'h100, 0, 0,     0, 0, 0,     0,    0, 0,    1, 0);
    add(1, 0, 0,     0,    0, 0,     0, 0,     0, 0, 0,     0,    0, 0,    1, 0);
    add(0, 0, 0,     0,    0, 0,     0, 0,     0, 1, 'h100, 0,    0, 0,    1, 0);
    add(0, 0, 0,     0,    0, 0,     1, 'h3C,  0, 0, 0,     0,    1, 'h3C, 0, 0);
    add(0, 0, 0,     0,    0, 0,     0, 0,     0, 0, 0,     0,    0, 'h3C, 0, 0);
    add(0, 0, 0,     0,    0, 0,     1, 'hEE,  0, 0, 0,     0,    0, 'h3C, 0, 0);
    add(0, 1, 'h20,  'h11, 1, 'h300, 0, 0,     0, 0, 0,     0,    0, 'h3C, 1, 0);
    add(0, 0, 0,     0,    0, 0,     0, 0,     1, 0, 'h20,  'h11, 0, 'h3C, 1, 0);
    add(0, 0, 0,     0,    0, 0,     1, 0,     0, 0, 0,     0,    0, 'h3C, 1, 0);
    add(0, 0, 0,     0,    0, 0,     0, 0,     0, 1, 'h300, 0,    0, 'h3C, 1, 0);
    add(0, 0, 0,     0,    0, 0,     1, 'h5A,  0, 0, 0,     0,    1, 'h5A, 0, 0);
    add(0, 1, 'h30,  'h22, 0, 0,     0, 0,     0, 0, 0,     0,    0, 'h5A, 1, 0);
    add(0, 0, 0,     0,    0, 0,     0, 0,     1, 0, 'h30,  'h22, 0, 'h5A, 1, 0);
    add(0, 0, 0,     0,    1, 'h200, 0, 0,     1, 0, 'h30,  'h22, 0, 'h5A, 1, 0);
    add(0, 0, 0,     0,    1, 'h201, 0, 0,     1, 0, 'h30,  'h22, 0, 'h5A, 1, 0);
    add(0, 0, 0,     0,    0, 0,     1, 0,     0, 0, 0,     0,    0, 'h5A, 1, 0);
    add(0, 0, 0,     0,    0, 0,     0, 0,     0, 1, 'h201, 0,    0, 'h5A, 1, 0);
    add(0, 0, 0,     0,    0, 0,     1, 'h77,  0, 0, 0,     0,    1, 'h77, 0, 0);
    add(0, 0, 0,     0,    0, 0,     0, 0,     0, 0, 0,     0,    0, 'h77, 0, 0);
    add(0, 0, 0,     0,    1, 'h40,  0, 0,     0, 0, 0,     0,    0, 'h77, 1, 0);
    add(0, 0, 0,     0,    0, 0,     0, 0,     0, 1, 'h40,  0,    0, 'h77, 1, 0);
    add(0, 0, 0,     0,    1, 'h41,  0, 0,     0, 1, 'h40,  0,    0, 'h77, 1, 0);
    add(0, 0, 0,     0,    0, 0,     1, 'h99,  0, 0, 0,     0,    1, 'h99, 1, 0);
    add(0, 0, 0,     0,    0, 0,     0, 0,     0, 1, 'h41,  0,    0, 'h99, 1, 0);
    add(0, 0, 0,     0,    0, 0,     1, 'h66,  0, 0, 0,     0,    1, 'h66, 0, 0);

    repeat (2) @(posedge clk);
    #3 reset_n = 1'b1;
    tick();

    foreach (tbl[i]) begin
      ld_active = tbl[i].la; ld_wr = tbl[i].wr; ld_addr = tbl[i].wa; ld_din = tbl[i].wd;
      tp_rd = tbl[i].rd; tp_addr = tbl[i].ra; mem_ack = tbl[i].ack; mem_dout = tbl[i].dout;
      tick();
      n_vec++;
      chk("mem_we", i, 32'(mem_we), 32'(tbl[i].e_we));
      chk("mem_rd", i, 32'(mem_rd), 32'(tbl[i].e_rd));
      if (tbl[i].e_we || tbl[i].e_rd) chk("mem_addr", i, 32'(mem_addr), 32'(tbl[i].e_addr));
      if (tbl[i].e_we) chk("mem_din", i, 32'(mem_din), 32'(tbl[i].e_din));
      chk("tp_valid", i, 32'(tp_valid), 32'(tbl[i].e_tv));
      chk("tp_dout", i, 32'(tp_dout), 32'(tbl[i].e_tdout));
      chk("busy", i, 32'(busy), 32'(tbl[i].e_busy));
      chk("ld_overflow", i, 32'(ld_overflow), 32'(tbl[i].e_ovf));
    end
    ld_active = 1'b0; ld_wr = 1'b0; tp_rd = 1'b0; mem_ack = 1'b0;

    // Burst of six strobes into a four-entry FIFO with the memory stalled.
    for (int i = 0; i < 6; i++) begin
      ld_wr = 1'b1; ld_addr = 25'('h50 + i); ld_din = 8'('hB0 + i);
      tick();
    end
    ld_wr = 1'b0;
    n_vec++;
    chk("burst_ovf_set", 100, 32'(ld_overflow), 32'd1);
    for (int i = 0; i < 4; i++) expect_write(110 + i, 25'('h50 + i), 8'('hB0 + i));
    repeat (3) tick();
    n_vec++;
    chk("burst_no_extra_we", 120, 32'(mem_we), 32'd0);
    chk("burst_idle", 121, 32'(busy), 32'd0);
    chk("burst_ovf_sticky", 122, 32'(ld_overflow), 32'd1);
    ld_active = 1'b1;
    tick();
    n_vec++;
    chk("ovf_clear_on_rise", 123, 32'(ld_overflow), 32'd0);
    ld_active = 1'b0;
    tick();

    // Full FIFO with a push landing on the same edge as the head's pop.
    for (int i = 0; i < 4; i++) begin
      ld_wr = 1'b1; ld_addr = 25'('h60 + i); ld_din = 8'('hC0 + i);
      tick();
    end
    ld_wr = 1'b0;
    n_vec++;
    chk("full_head_addr", 130, 32'(mem_addr), 32'h60);
    chk("full_head_we", 131, 32'(mem_we), 32'd1);
    mem_ack = 1'b1; ld_wr = 1'b1; ld_addr = 25'h64; ld_din = 8'hC4;
    tick();
    mem_ack = 1'b0; ld_wr = 1'b0;
    chk("full_pop_push_ovf", 132, 32'(ld_overflow), 32'd0);
    for (int i = 1; i < 5; i++) expect_write(140 + i, 25'('h60 + i), 8'('hC0 + i));
    repeat (2) tick();
    n_vec++;
    chk("full_drained", 150, 32'(busy), 32'd0);

    // Asynchronous reset while a read command is outstanding.
    tp_rd = 1'b1; tp_addr = 25'h77;
    tick();
    tp_rd = 1'b0;
    tick();
    n_vec++;
    chk("rst_pre_rd", 160, 32'(mem_rd), 32'd1);
    #2 reset_n = 1'b0;
    #1;
    chk("rst_async_rd", 161, 32'(mem_rd), 32'd0);
    chk("rst_async_busy", 162, 32'(busy), 32'd0);
    #3 reset_n = 1'b1;
    for (int i = 0; i < 4; i++) begin
      tick();
      n_vec++;
      chk("post_rst_rd", 170 + i, 32'(mem_rd), 32'd0);
      chk("post_rst_we", 170 + i, 32'(mem_we), 32'd0);
      chk("post_rst_busy", 170 + i, 32'(busy), 32'd0);
    end
    tp_rd = 1'b1; tp_addr = 25'h88;
    tick();
    tp_rd = 1'b0;
    tick();
    n_vec++;
    chk("post_rst_new_rd", 180, 32'(mem_rd), 32'd1);
    chk("post_rst_new_addr", 181, 32'(mem_addr), 32'h88);
    mem_ack = 1'b1; mem_dout = 8'h12;
    tick();
    mem_ack = 1'b0;
    chk("post_rst_tv", 182, 32'(tp_valid), 32'd1);
    chk("post_rst_tdout", 183, 32'(tp_dout), 32'h12);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
